// File: rtl/tlk2711_pkg.sv
// Shared definitions for the TLK2711 transmit command arbiter.
// Holds the arbiter FSM state type and the default widths used for the
// DMA address, DMA command length and body-packet count.
package tlk2711_pkg;

    localparam int DEF_ADDR_WIDTH = 48;
    localparam int DEF_DLEN_WIDTH = 16;
    localparam int DEF_CNT_WIDTH  = 24;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARB,
        ST_REQ,
        ST_WAIT_LAST
    } arb_state_e;

endpackage

// File: rtl/tlk2711_rr_arb.sv
// Round-robin request selector.
// Ports:
//   clk, rst   - clock and synchronous active-high reset (pointer back to 0)
//   req        - one request bit per channel
//   advance    - strobe: the current grant was taken, move the pointer past it
//   grant      - one-hot grant of the first requester at or after the pointer
//   grant_idx  - binary index of that grant
module tlk2711_rr_arb #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic [IDX_W-1:0] ptr;
    int               idx;

    // Search from the pointer upwards with wrap-around. The loop runs from
    // the farthest offset down to the nearest, so the nearest requester is
    // the one whose assignment survives.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        idx       = 0;
        for (int off = N - 1; off >= 0; off--) begin
            idx = int'(ptr) + off;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_idx  = IDX_W'(idx);
            end
        end
    end

    // The pointer holds the first channel to consider next time, i.e. the
    // channel after the one most recently granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/tlk2711_tx_cmd_arb.sv
// TLK2711 transmit DMA read-command arbiter.
// Each channel is started with a base address, body length, tail length and
// body count; its packet sequence (body packets, then an optional tail) is
// turned into DMA read commands, one outstanding at a time, with channels
// served round-robin.
// Ports:
//   clk, rst, i_soft_rst          - clock, synchronous active-high resets
//   i_tx_start                    - per-channel start pulse
//   i_tx_base_addr / _packet_body / _packet_tail / _body_num
//                                 - per-channel configuration, slice i at [i*W +: W]
//   o_rd_cmd_req/_data/_ch        - command request, {length, address}, owner
//   i_rd_cmd_ack, i_dma_rd_last   - command accepted, last read beat
//   o_ch_busy, o_ch_done, o_start_err - per-channel status and pulses
module tlk2711_tx_cmd_arb
    import tlk2711_pkg::*;
#(
    parameter int  NUM_CH     = 4,
    parameter int  ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int  DLEN_WIDTH = DEF_DLEN_WIDTH,
    parameter int  CNT_WIDTH  = DEF_CNT_WIDTH,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_soft_rst,
    input  logic [NUM_CH-1:0]                i_tx_start,
    input  logic [NUM_CH*ADDR_WIDTH-1:0]     i_tx_base_addr,
    input  logic [NUM_CH*DLEN_WIDTH-1:0]     i_tx_packet_body,
    input  logic [NUM_CH*DLEN_WIDTH-1:0]     i_tx_packet_tail,
    input  logic [NUM_CH*CNT_WIDTH-1:0]      i_tx_body_num,
    output logic                             o_rd_cmd_req,
    output logic [DLEN_WIDTH+ADDR_WIDTH-1:0] o_rd_cmd_data,
    output logic [CH_W-1:0]                  o_rd_cmd_ch,
    input  logic                             i_rd_cmd_ack,
    input  logic                             i_dma_rd_last,
    output logic [NUM_CH-1:0]                o_ch_busy,
    output logic [NUM_CH-1:0]                o_ch_done,
    output logic [NUM_CH-1:0]                o_start_err
);

    arb_state_e            state;
    logic                  sync_rst;
    logic [ADDR_WIDTH-1:0] ctx_addr     [NUM_CH];
    logic [DLEN_WIDTH-1:0] ctx_body_len [NUM_CH];
    logic [DLEN_WIDTH-1:0] ctx_tail_len [NUM_CH];
    logic [CNT_WIDTH-1:0]  ctx_body_cnt [NUM_CH];
    logic [NUM_CH-1:0]     ctx_tail_pend;
    logic [NUM_CH-1:0]     pending;
    logic [NUM_CH-1:0]     start_empty;
    logic [NUM_CH-1:0]     grant_oh;
    logic [CH_W-1:0]       grant_idx;
    logic [DLEN_WIDTH-1:0] grant_len;
    logic [DLEN_WIDTH-1:0] cmd_len;
    logic                  cmd_last;
    logic                  handshake;
    logic                  completion;

    assign sync_rst   = rst | i_soft_rst;
    assign cmd_len    = o_rd_cmd_data[ADDR_WIDTH +: DLEN_WIDTH];
    assign handshake  = (state == ST_REQ) && i_rd_cmd_ack;
    assign completion = (state == ST_WAIT_LAST) && i_dma_rd_last;

    // A context has work while body packets remain or the tail is unsent.
    // A start is empty when it would produce no packet at all.
    always_comb begin
        pending     = '0;
        start_empty = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pending[i]     = (ctx_body_cnt[i] != '0) || ctx_tail_pend[i];
            start_empty[i] = ((i_tx_packet_body[i*DLEN_WIDTH +: DLEN_WIDTH] == '0) ||
                              (i_tx_body_num[i*CNT_WIDTH +: CNT_WIDTH] == '0)) &&
                             (i_tx_packet_tail[i*DLEN_WIDTH +: DLEN_WIDTH] == '0);
        end
    end

    // Length of the next packet of the granted channel: body while bodies
    // remain, otherwise the tail.
    always_comb begin
        grant_len = (ctx_body_cnt[grant_idx] != '0) ? ctx_body_len[grant_idx]
                                                    : ctx_tail_len[grant_idx];
    end

    tlk2711_rr_arb #(
        .N     (NUM_CH),
        .IDX_W (CH_W)
    ) u_rr_arb (
        .clk       (clk),
        .rst       (sync_rst),
        .req       (pending),
        .advance   ((state == ST_ARB) && (|grant_oh)),
        .grant     (grant_oh),
        .grant_idx (grant_idx)
    );

    // Command FSM. The command is captured at the ARB edge and then held
    // untouched until the DMA acknowledges it.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state         <= ST_IDLE;
            o_rd_cmd_req  <= 1'b0;
            o_rd_cmd_data <= '0;
            o_rd_cmd_ch   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|pending) begin
                        state <= ST_ARB;
                    end
                end
                ST_ARB: begin
                    if (|grant_oh) begin
                        state         <= ST_REQ;
                        o_rd_cmd_req  <= 1'b1;
                        o_rd_cmd_data <= {grant_len, ctx_addr[grant_idx]};
                        o_rd_cmd_ch   <= grant_idx;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (i_rd_cmd_ack) begin
                        state        <= ST_WAIT_LAST;
                        o_rd_cmd_req <= 1'b0;
                    end
                end
                ST_WAIT_LAST: begin
                    if (i_dma_rd_last) begin
                        state <= (|pending) ? ST_ARB : ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Channel contexts and status. On the handshake the granted context
    // advances and we remember whether that was its final packet, so the
    // done pulse and busy release can be issued when its read completes.
    // Busy is still set in the completion cycle, so a start arriving then
    // is rejected.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                ctx_addr[i]     <= '0;
                ctx_body_len[i] <= '0;
                ctx_tail_len[i] <= '0;
                ctx_body_cnt[i] <= '0;
            end
            ctx_tail_pend <= '0;
            cmd_last      <= 1'b0;
            o_ch_busy     <= '0;
            o_ch_done     <= '0;
            o_start_err   <= '0;
        end else begin
            o_ch_done   <= '0;
            o_start_err <= '0;

            if (handshake) begin
                ctx_addr[o_rd_cmd_ch] <= ctx_addr[o_rd_cmd_ch] + ADDR_WIDTH'(cmd_len);
                if (ctx_body_cnt[o_rd_cmd_ch] != '0) begin
                    ctx_body_cnt[o_rd_cmd_ch] <= ctx_body_cnt[o_rd_cmd_ch] - CNT_WIDTH'(1);
                    cmd_last <= (ctx_body_cnt[o_rd_cmd_ch] == CNT_WIDTH'(1)) &&
                                !ctx_tail_pend[o_rd_cmd_ch];
                end else begin
                    ctx_tail_pend[o_rd_cmd_ch] <= 1'b0;
                    cmd_last                   <= 1'b1;
                end
            end

            if (completion && cmd_last) begin
                o_ch_done[o_rd_cmd_ch] <= 1'b1;
                o_ch_busy[o_rd_cmd_ch] <= 1'b0;
            end

            for (int i = 0; i < NUM_CH; i++) begin
                if (i_tx_start[i]) begin
                    if (o_ch_busy[i]) begin
                        o_start_err[i] <= 1'b1;
                    end else if (start_empty[i]) begin
                        o_ch_done[i] <= 1'b1;
                    end else begin
                        ctx_addr[i]      <= i_tx_base_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                        ctx_body_len[i]  <= i_tx_packet_body[i*DLEN_WIDTH +: DLEN_WIDTH];
                        ctx_tail_len[i]  <= i_tx_packet_tail[i*DLEN_WIDTH +: DLEN_WIDTH];
                        ctx_body_cnt[i]  <= (i_tx_packet_body[i*DLEN_WIDTH +: DLEN_WIDTH] == '0) ?
                                            '0 : i_tx_body_num[i*CNT_WIDTH +: CNT_WIDTH];
                        ctx_tail_pend[i] <= (i_tx_packet_tail[i*DLEN_WIDTH +: DLEN_WIDTH] != '0);
                        o_ch_busy[i]     <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_tlk2711_tx_cmd_arb.sv
// Self-checking bench for tlk2711_tx_cmd_arb. Expected commands come from a
// packet-list model: each started channel expands into its list of
// {length, address} packets, and the lists are interleaved round-robin.
module tb_tlk2711_tx_cmd_arb;

    localparam int NUM_CH = 4;
    localparam int AW     = 48;
    localparam int DW     = 16;
    localparam int CW     = 24;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   i_soft_rst;
    logic [NUM_CH-1:0]      i_tx_start;
    logic [NUM_CH*AW-1:0]   i_tx_base_addr;
    logic [NUM_CH*DW-1:0]   i_tx_packet_body;
    logic [NUM_CH*DW-1:0]   i_tx_packet_tail;
    logic [NUM_CH*CW-1:0]   i_tx_body_num;
    logic                   o_rd_cmd_req;
    logic [DW+AW-1:0]       o_rd_cmd_data;
    logic [1:0]             o_rd_cmd_ch;
    logic                   i_rd_cmd_ack;
    logic                   i_dma_rd_last;
    logic [NUM_CH-1:0]      o_ch_busy;
    logic [NUM_CH-1:0]      o_ch_done;
    logic [NUM_CH-1:0]      o_start_err;

    typedef struct packed {
        logic [1:0]  ch;
        logic [15:0] len;
        logic [47:0] addr;
        logic        last;
    } cmd_t;

    cmd_t pend_q[$];
    cmd_t exp_q[$];
    int   model_ptr = 0;
    int   checks    = 0;
    int   errors    = 0;

    tlk2711_tx_cmd_arb #(
        .NUM_CH     (NUM_CH),
        .ADDR_WIDTH (AW),
        .DLEN_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .i_soft_rst       (i_soft_rst),
        .i_tx_start       (i_tx_start),
        .i_tx_base_addr   (i_tx_base_addr),
        .i_tx_packet_body (i_tx_packet_body),
        .i_tx_packet_tail (i_tx_packet_tail),
        .i_tx_body_num    (i_tx_body_num),
        .o_rd_cmd_req     (o_rd_cmd_req),
        .o_rd_cmd_data    (o_rd_cmd_data),
        .o_rd_cmd_ch      (o_rd_cmd_ch),
        .i_rd_cmd_ack     (i_rd_cmd_ack),
        .i_dma_rd_last    (i_dma_rd_last),
        .o_ch_busy        (o_ch_busy),
        .o_ch_done        (o_ch_done),
        .o_start_err      (o_start_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_req"},  64'(o_rd_cmd_req), 64'd0);
        checkOutput({tag, "_data"}, 64'(o_rd_cmd_data), 64'd0);
        checkOutput({tag, "_ch"},   64'(o_rd_cmd_ch), 64'd0);
        checkOutput({tag, "_busy"}, 64'(o_ch_busy), 64'd0);
        checkOutput({tag, "_done"}, 64'(o_ch_done), 64'd0);
        checkOutput({tag, "_err"},  64'(o_start_err), 64'd0);
    endtask

    // Drives one channel's configuration and raises its start bit. When the
    // start is expected to be accepted its packet list is added to the model.
    task automatic applyStimulus(input int ch, input logic [47:0] addr,
                                 input logic [15:0] body, input logic [15:0] tail,
                                 input logic [23:0] num, input bit accept,
                                 output bit empty);
        int          total;
        logic [47:0] a;
        i_tx_base_addr[ch*AW +: AW]   = addr;
        i_tx_packet_body[ch*DW +: DW] = body;
        i_tx_packet_tail[ch*DW +: DW] = tail;
        i_tx_body_num[ch*CW +: CW]    = num;
        i_tx_start[ch]                = 1'b1;
        total = ((body != 0) ? int'(num) : 0) + ((tail != 0) ? 1 : 0);
        empty = (total == 0);
        a     = addr;
        if (accept) begin
            for (int k = 0; k < total; k++) begin
                cmd_t e;
                e.ch   = 2'(ch);
                e.last = (k == total - 1);
                e.addr = a;
                if (body != 0 && k < int'(num)) begin
                    e.len = body;
                    a     = a + 48'(body);
                end else begin
                    e.len = tail;
                end
                pend_q.push_back(e);
            end
        end
    endtask

    task automatic pulseStart();
        step();
        i_tx_start = '0;
    endtask

    // Interleaves the pending packet lists round-robin into the expected
    // command order.
    task automatic mergeRR();
        int c;
        bit took;
        while (pend_q.size() > 0) begin
            took = 0;
            for (int off = 0; off < NUM_CH && !took; off++) begin
                c = (model_ptr + off) % NUM_CH;
                for (int j = 0; j < pend_q.size() && !took; j++) begin
                    if (int'(pend_q[j].ch) == c) begin
                        exp_q.push_back(pend_q[j]);
                        pend_q.delete(j);
                        model_ptr = (c + 1) % NUM_CH;
                        took      = 1;
                    end
                end
            end
        end
    endtask

    task automatic modelReset();
        pend_q.delete();
        exp_q.delete();
        model_ptr = 0;
    endtask

    task automatic waitReq();
        int waited = 0;
        while (o_rd_cmd_req !== 1'b1 && waited < 40) begin
            step();
            waited++;
        end
        checkOutput("req_seen", 64'(o_rd_cmd_req), 64'd1);
    endtask

    // Plays the DMA side for one expected command: checks it, holds ack low
    // for ack_dly cycles (with stray rd_last), acks, waits last_dly cycles
    // (with stray acks), then signals rd_last and checks the completion.
    task automatic serveOne(input int ack_dly, input int last_dly, input bit restart);
        cmd_t       e;
        logic [3:0] onehot;
        e = exp_q.pop_front();
        waitReq();
        if (o_rd_cmd_req !== 1'b1) return;
        onehot = 4'b0001 << e.ch;
        checkOutput("cmd_ch", 64'(o_rd_cmd_ch), 64'(e.ch));
        checkOutput("cmd_data", 64'(o_rd_cmd_data), {e.len, e.addr});
        for (int k = 0; k < ack_dly; k++) begin
            i_dma_rd_last = 1'($urandom_range(0, 1));
            step();
            checkOutput("hold_req", 64'(o_rd_cmd_req), 64'd1);
            checkOutput("hold_data", 64'(o_rd_cmd_data), {e.len, e.addr});
            checkOutput("hold_ch", 64'(o_rd_cmd_ch), 64'(e.ch));
        end
        i_dma_rd_last = 1'b0;
        i_rd_cmd_ack  = 1'b1;
        step();
        i_rd_cmd_ack = 1'b0;
        checkOutput("req_drop", 64'(o_rd_cmd_req), 64'd0);
        for (int k = 0; k < last_dly; k++) begin
            i_rd_cmd_ack = 1'($urandom_range(0, 1));
            step();
            checkOutput("no_early_req", 64'(o_rd_cmd_req), 64'd0);
        end
        i_rd_cmd_ack  = 1'b0;
        i_dma_rd_last = 1'b1;
        if (restart) i_tx_start[e.ch] = 1'b1;
        step();
        i_dma_rd_last = 1'b0;
        i_tx_start    = '0;
        checkOutput("done", 64'(o_ch_done), e.last ? 64'(onehot) : 64'd0);
        checkOutput("start_err", 64'(o_start_err), restart ? 64'(onehot) : 64'd0);
        checkOutput("busy_after", 64'(o_ch_busy[e.ch]), 64'(!e.last));
    endtask

    task automatic serveAll();
        while (exp_q.size() > 0) begin
            serveOne($urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
        end
    endtask

    initial begin
        bit         empty;
        logic [3:0] busy_exp;
        logic [3:0] done_exp;
        logic [3:0] mask;
        logic [15:0] body;
        logic [15:0] tail;

        rst              = 1'b1;
        i_soft_rst       = 1'b0;
        i_tx_start       = '0;
        i_tx_base_addr   = '0;
        i_tx_packet_body = '0;
        i_tx_packet_tail = '0;
        i_tx_body_num    = '0;
        i_rd_cmd_ack     = 1'b0;
        i_dma_rd_last    = 1'b0;
        repeat (3) step();
        checkAllZero("reset");
        rst = 1'b0;
        step();
        checkAllZero("idle");

        $display("[TB] single channel body/body/tail with start latency");
        applyStimulus(0, 48'h1000, 16'd256, 16'd64, 24'd2, 1'b1, empty);
        mergeRR();
        pulseStart();
        checkOutput("lat_busy", 64'(o_ch_busy), 64'h1);
        checkOutput("lat_k", 64'(o_rd_cmd_req), 64'd0);
        step();
        checkOutput("lat_k1", 64'(o_rd_cmd_req), 64'd0);
        step();
        checkOutput("lat_k2", 64'(o_rd_cmd_req), 64'd1);
        serveOne(10, 2, 1'b0);
        serveOne(0, 0, 1'b0);
        serveOne(3, 1, 1'b0);

        $display("[TB] four channels round-robin after soft reset");
        i_soft_rst = 1'b1;
        step();
        i_soft_rst = 1'b0;
        modelReset();
        checkAllZero("soft_rst_idle");
        for (int c = 0; c < NUM_CH; c++) begin
            applyStimulus(c, 48'h2000_0000 + 48'(c) * 48'h1_0000, 16'h40 * 16'(c + 1),
                          16'd0, 24'd2, 1'b1, empty);
        end
        mergeRR();
        pulseStart();
        checkOutput("rr_busy", 64'(o_ch_busy), 64'hf);
        serveAll();

        $display("[TB] rejected start, empty start, start at completion");
        applyStimulus(1, 48'h3000, 16'd128, 16'd0, 24'd3, 1'b1, empty);
        mergeRR();
        pulseStart();
        checkOutput("rej_busy0", 64'(o_ch_busy), 64'h2);
        applyStimulus(1, 48'hdead0, 16'd32, 16'd32, 24'd7, 1'b0, empty);
        applyStimulus(2, 48'h5000, 16'd0, 16'd0, 24'd5, 1'b1, empty);
        pulseStart();
        checkOutput("rej_err", 64'(o_start_err), 64'h2);
        checkOutput("empty_done", 64'(o_ch_done), 64'h4);
        checkOutput("rej_busy1", 64'(o_ch_busy), 64'h2);
        step();
        checkOutput("rej_err_clear", 64'(o_start_err), 64'd0);
        checkOutput("empty_done_clear", 64'(o_ch_done), 64'd0);
        serveOne(2, 1, 1'b0);
        serveOne(0, 2, 1'b0);
        serveOne(1, 1, 1'b1);
        repeat (4) begin
            step();
            checkOutput("no_cmd_after_reject", 64'(o_rd_cmd_req), 64'd0);
        end

        $display("[TB] address wrap");
        applyStimulus(0, 48'hFFFF_FFFF_FF80, 16'd256, 16'd0, 24'd2, 1'b1, empty);
        mergeRR();
        pulseStart();
        serveAll();

        $display("[TB] soft reset in WAIT_LAST, pointer restart");
        applyStimulus(2, 48'h7000, 16'd64, 16'd0, 24'd1, 1'b1, empty);
        mergeRR();
        pulseStart();
        waitReq();
        i_rd_cmd_ack = 1'b1;
        step();
        i_rd_cmd_ack = 1'b0;
        step();
        i_soft_rst = 1'b1;
        step();
        i_soft_rst = 1'b0;
        modelReset();
        checkAllZero("soft_rst_wait_last");
        i_dma_rd_last = 1'b1;
        step();
        i_dma_rd_last = 1'b0;
        checkAllZero("stale_last");
        applyStimulus(3, 48'h8000, 16'd32, 16'd0, 24'd1, 1'b1, empty);
        applyStimulus(0, 48'h9000, 16'd48, 16'd0, 24'd1, 1'b1, empty);
        mergeRR();
        pulseStart();
        serveAll();

        $display("[TB] hard reset during REQ");
        applyStimulus(1, 48'hA000, 16'd16, 16'd0, 24'd1, 1'b1, empty);
        mergeRR();
        pulseStart();
        waitReq();
        rst          = 1'b1;
        i_rd_cmd_ack = 1'b1;
        step();
        rst          = 1'b0;
        i_rd_cmd_ack = 1'b0;
        modelReset();
        checkAllZero("rst_in_req");
        repeat (3) begin
            step();
            checkOutput("no_req_after_rst", 64'(o_rd_cmd_req), 64'd0);
        end

        $display("[TB] randomized rounds");
        for (int r = 0; r < 12; r++) begin
            mask     = 4'($urandom_range(1, 15));
            busy_exp = '0;
            done_exp = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                if (mask[c]) begin
                    body = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 4096));
                    tail = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(1, 512)) : 16'd0;
                    applyStimulus(c, {16'($urandom), 32'($urandom)}, body, tail,
                                  24'($urandom_range(0, 3)), 1'b1, empty);
                    if (empty) done_exp[c] = 1'b1;
                    else       busy_exp[c] = 1'b1;
                end
            end
            mergeRR();
            pulseStart();
            checkOutput("rnd_done", 64'(o_ch_done), 64'(done_exp));
            checkOutput("rnd_busy", 64'(o_ch_busy), 64'(busy_exp));
            checkOutput("rnd_err", 64'(o_start_err), 64'd0);
            serveAll();
        end
        step();
        checkOutput("final_busy", 64'(o_ch_busy), 64'd0);
        checkOutput("final_req", 64'(o_rd_cmd_req), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tlk2711_tx_cmd_arb.md
TLK2711_TX_CMD_ARB -- requirements
Module: tlk2711_tx_cmd_arb

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent TX command channels (1..8).
REQ-002 Parameter ADDR_WIDTH, default 48: DMA byte address width.
REQ-003 Parameter DLEN_WIDTH, default 16: DMA command length width.
REQ-004 Parameter CNT_WIDTH, default 24: body-packet count width.
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 i_soft_rst  in  1  software reset, synchronous, active-high.
REQ-008 i_tx_start  in  NUM_CH  per-channel start pulse, one cycle.
REQ-009 i_tx_base_addr  in  NUM_CH*ADDR_WIDTH  per-channel start address.
REQ-010 i_tx_packet_body  in  NUM_CH*DLEN_WIDTH  body packet length in bytes.
REQ-011 i_tx_packet_tail  in  NUM_CH*DLEN_WIDTH  tail packet length in bytes; 0 means no tail.
REQ-012 i_tx_body_num  in  NUM_CH*CNT_WIDTH  number of body packets.
REQ-013 o_rd_cmd_req  out  1  DMA read command request.
REQ-014 o_rd_cmd_data  out  DLEN_WIDTH+ADDR_WIDTH  {length, address}; length in the MSBs.
REQ-015 o_rd_cmd_ch  out  clog2(NUM_CH) (min 1)  channel owning the current command.
REQ-016 i_rd_cmd_ack  in  1  DMA accepted the command.
REQ-017 i_dma_rd_last  in  1  last beat of the current command's read data.
REQ-018 o_ch_busy  out  NUM_CH  channel holds pending or in-flight packets.
REQ-019 o_ch_done  out  NUM_CH  one-cycle pulse when a channel's final read completes.
REQ-020 o_start_err  out  NUM_CH  one-cycle pulse when a start is rejected.

Function
REQ-021 Slice i of each per-channel bus SHALL occupy bits [(i+1)*W-1 : i*W].
REQ-022 A start on an idle channel SHALL latch that channel's address, body length, tail length and body count into a per-channel context; o_ch_busy[i] SHALL assert on the next cycle.
REQ-023 A start on a busy channel SHALL be ignored and SHALL pulse o_start_err[i] on the next cycle.
REQ-024 Each channel's packet sequence SHALL be body_num body packets followed by one tail packet if tail is nonzero; body packets SHALL be skipped if body length is 0.
REQ-025 A start with an empty sequence SHALL pulse o_ch_done[i] on the next cycle, issue no command, and leave busy low.
REQ-026 The FSM SHALL have states IDLE, ARB, REQ and WAIT_LAST.
REQ-027 IDLE->ARB occurs when any context has packets pending.
REQ-028 ARB (one cycle) SHALL grant the next pending channel after the last granted one, round-robin, then go to REQ.
REQ-029 In REQ, o_rd_cmd_req=1 and o_rd_cmd_data/o_rd_cmd_ch SHALL be held stable until the cycle in which i_rd_cmd_ack=1; that cycle completes the handshake and moves to WAIT_LAST.
REQ-030 On ack, the granted context SHALL advance: address += length (modulo 2^ADDR_WIDTH), and either the body count decrements or the tail is marked consumed.
REQ-031 WAIT_LAST SHALL leave on i_dma_rd_last: to ARB if any channel is pending, else to IDLE; if the completed packet was its channel's last, o_ch_done pulses and busy drops on the next cycle.
REQ-032 i_dma_rd_last outside WAIT_LAST and i_rd_cmd_ack outside REQ SHALL be ignored.
REQ-033 Only one command SHALL be outstanding at a time.
REQ-034 Latency: a start sampled at edge k with the FSM in IDLE SHALL give o_rd_cmd_req=1 after edge k+2.
REQ-035 A start arriving in the same cycle as that channel's done pulse SHALL be rejected (busy is still high).

Reset
REQ-036 rst or i_soft_rst SHALL clear all contexts and the round-robin pointer (next grant is channel 0), force IDLE, and drive all outputs to 0 on the next cycle, including mid-handshake; no done pulse is generated.

Structure
REQ-037 Package tlk2711_pkg SHALL hold the FSM state enum and the default ADDR_WIDTH, DLEN_WIDTH and CNT_WIDTH constants.
REQ-038 Round-robin selection SHALL be a sub-module tlk2711_rr_arb (request vector in; one-hot grant and index out; pointer update on an advance strobe).

Verification
REQ-039 Single channel: ch0 body=256, num=2, tail=64, addr=0x1000 -> commands {256,0x1000}, {256,0x1100}, {64,0x1200}, each after the previous rd_last; then one done[0] pulse.
REQ-040 Round-robin: ch0..ch3 started together, num=2 each, tail=0 -> grant order 0,1,2,3,0,1,2,3; done pulses in order 0..3.
REQ-041 Ack held low 10 cycles -> req and data stable for all 10 cycles; exactly one context advance.
REQ-042 Start on a busy ch1 -> o_start_err[1] pulse; ch1 sequence unchanged; body=0, num=5, tail=0 on ch2 -> done[2] next cycle, no command.
REQ-043 Address wrap: addr=2^48-128, body=256, num=2 -> second command address 0x80.
REQ-044 Soft reset asserted in WAIT_LAST -> all outputs 0 next cycle; a later start on ch3 is granted first among ch0/ch3 only if ch0 is idle, i.e. the pointer restarts at 0.
